// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: opcode constants and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_NOT    = 4'd2;
  localparam logic [3:0] ALU_SHL    = 4'd3;
  localparam logic [3:0] ALU_SHR    = 4'd4;
  localparam logic [3:0] ALU_AND    = 4'd5;
  localparam logic [3:0] ALU_OR     = 4'd6;
  localparam logic [3:0] ALU_SLT    = 4'd7;
  localparam logic [3:0] ALU_LUI    = 4'd8;
  localparam logic [3:0] ALU_LLI    = 4'd9;
  localparam logic [3:0] ALU_OP_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker; first requester after last, wrapping.
module rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = (int'(last) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external ALU among NUM_REQ requesters, IDLE->EXEC->RESP.
// Optional macro ALU_OP_CHECK_EN adds resp_err and short-circuits illegal opcodes.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]  req_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_control,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_result,
  output logic                  resp_zero,
  output logic [ID_W-1:0]       resp_id,
  output logic [1:0]            state
`ifdef ALU_OP_CHECK_EN
  ,
  output logic                  resp_err
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // req_ready is high only in IDLE for the single round-robin winner, resp_valid only in RESP.

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic [31:0]        a_q, b_q, a_sel, b_sel;
  logic [3:0]         op_q, op_sel;
  logic               accept;
  logic               illegal_sel;

  rr_grant #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_grant (
    .req   (req_valid),
    .last  (last_grant),
    .grant (win_grant),
    .idx   (win_idx)
  );

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        a_sel  = req_a[32*i +: 32];
        b_sel  = req_b[32*i +: 32];
        op_sel = req_op[4*i +: 4];
      end
    end
  end

`ifdef ALU_OP_CHECK_EN
  assign illegal_sel = (op_sel > ALU_OP_MAX);
`else
  assign illegal_sel = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = win_grant;
        accept    = |(req_valid & win_grant);
        if (accept) state_d = illegal_sel ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_id     <= '0;
`ifdef ALU_OP_CHECK_EN
      resp_err    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q        <= a_sel;
        b_q        <= b_sel;
        op_q       <= op_sel;
        last_grant <= win_idx;
        resp_id    <= win_idx;
`ifdef ALU_OP_CHECK_EN
        resp_err   <= illegal_sel;
        if (illegal_sel) begin
          resp_result <= '0;
          resp_zero   <= 1'b1;
        end
`endif
      end
      if (state_q == ST_EXEC) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
      end
    end
  end

  // ALU inputs come straight from the operand registers, so they only move on an accept.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
  assign resp_valid  = (state_q == ST_RESP);
  assign state       = state_q;

endmodule
